dice_router_cfg_loader: RTL
===========================

Name: dice_router_cfg_loader

Overview:
Upstream configuration stage for the per-tile DICE routers. It accepts a configuration frame as a valid/ready word stream and assembles it into a shadow register. On a commit request it atomically transfers the frame into the active register, which drives the router's per-slot select and registered-mode inputs. Double buffering lets the next routing context load while the current one keeps running.

Parameters:
- NUM_SLOTS, 11, number of router output slots (the 2x1 router has 5 directions, 11 time slots in total).
- SEL_W, 4, width of each slot's select field.
- MAX_SEL, 8, highest legal select code.
- CFG_W, 16, width of one stream word.
- (derived) FRAME_W = NUM_SLOTS*(SEL_W+1); BEATS = ceil(FRAME_W/CFG_W), which is 4 at the defaults.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  stream word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_data  in  CFG_W  stream word; the frame is packed LSB-first.
- cfg_last  in  1  marks the final word of the frame.
- cfg_commit  in  1  single-cycle request to activate the shadow frame.
- sel_flat  out  NUM_SLOTS*SEL_W  active selects; slot i occupies [i*SEL_W +: SEL_W].
- regmode  out  NUM_SLOTS  active registered_mode bits; slot i is bit i.
- active_valid  out  1  the active register holds a committed frame.
- shadow_full  out  1  a complete, checked frame is waiting for commit.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset is synchronous and active-high. Values after reset:
  - sel_flat = all ones (illegal code, so the router outputs 0).
  - regmode = 0, active_valid = 0, shadow_full = 0, frame_err = 0.
  - The beat counter is 0 and the FSM is in IDLE.
- Frame layout: slot i uses frame bits [i*(SEL_W+1) +: SEL_W] for sel and bit i*(SEL_W+1)+SEL_W for regmode. Word k fills frame bits [k*CFG_W +: CFG_W]. Bits above FRAME_W in the last word are ignored.
- A word transfers when cfg_valid && cfg_ready.
- FSM states are IDLE, LOAD, FULL.
  - IDLE: cfg_ready = 1. The first transfer writes word 0, sets beat counter = 1 and moves to LOAD. If that word also has cfg_last and BEATS != 1, it is an error.
  - LOAD: cfg_ready = 1. Each transfer writes word[beat] and increments the counter.
  - Frame completes when the beat with index BEATS-1 transfers:
    - It must carry cfg_last and every slot's sel must be <= MAX_SEL. Then shadow_full is set on the next cycle and the FSM moves to FULL.
    - Otherwise frame_err pulses, the shadow is discarded and the FSM returns to IDLE.
  - Early cfg_last (at a beat index below BEATS-1): frame_err pulses, the frame is discarded, and the FSM returns to IDLE.
  - FULL: cfg_ready = 0.
- Commit:
  - cfg_commit in FULL: one cycle later the active register equals the shadow, active_valid = 1, shadow_full = 0, and the FSM is in IDLE. cfg_ready rises in the same cycle as the active update.
  - cfg_commit in IDLE, or in LOAD before the completing beat: sets a commit_pending flag.
  - While pending, a frame that completes cleanly is committed automatically on the cycle after completion and never sits visibly in FULL. From completion, latency is 2 cycles: the shadow is written at completion, and active is written on the next edge.
  - A frame error clears commit_pending.
- Simultaneous commit and completing beat in LOAD: the request counts as pending, so the frame auto-commits.
- A commit while already pending is idempotent.
- The active register changes only on a commit, never mid-frame. Routing therefore stays stable while the next context loads.
- Reset asserted mid-frame:
  - The partial shadow is discarded, pending is cleared and the FSM enters IDLE.
  - Active returns to its reset values.
- Outputs are registered, so the router inputs never see combinational paths from the stream.

Decomposition:
- Shared package dice_router_cfg_pkg holds:
  - the state enum (IDLE/LOAD/FULL);
  - the defaults NUM_SLOTS, SEL_W, MAX_SEL, CFG_W;
  - the FRAME_W and BEATS localparams;
  - SEL_RESET = '1.
- One sub-module: dice_cfg_frame_checker, a combinational check that every slot's sel is <= MAX_SEL, instantiated on the shadow plus the incoming word.
- Everything else is flat.

Test Plan:
- Reset: after rst, sel_flat = all 0xF, regmode = 0, active_valid = 0 and cfg_ready = 1.
- Legal frame: 4 words with slot0 sel = 8 and regmode = 1, all other slots sel = 2, last on word 3. Result: shadow_full = 1 and cfg_ready = 0. A commit then gives sel_flat[3:0] = 8, regmode[0] = 1 and active_valid = 1 one cycle later.
- Early commit: pulse cfg_commit in IDLE, then stream a legal frame with valid gaps between words. Result: active updates 2 cycles after word 3 and shadow_full is never seen high.
- Errors:
  - Early cfg_last on word 1: frame_err pulses for 1 cycle, the FSM returns to IDLE, and active is unchanged.
  - sel = 9 in slot 5: frame_err pulses, and the pending commit is dropped.
- Double buffer: with frame A active, load frame B while cfg_ready toggles. Active stays equal to A until the commit, then equals B.
- Reset mid-frame: assert rst after 2 words. Result: shadow discarded, active resets to 0xF / 0, and a fresh 4-word frame loads normally.

Source files
------------

// File: rtl/dice_router_cfg_pkg.sv
// Shared types and sizing for the DICE router configuration loader.
package dice_router_cfg_pkg;

    localparam int NUM_SLOTS = 11;
    localparam int SEL_W     = 4;
    localparam int MAX_SEL   = 8;
    localparam int CFG_W     = 16;

    localparam int SLOT_W  = SEL_W + 1;
    localparam int FRAME_W = NUM_SLOTS * SLOT_W;
    localparam int BEATS   = (FRAME_W + CFG_W - 1) / CFG_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [NUM_SLOTS*SEL_W-1:0] SEL_RESET = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/dice_cfg_frame_checker.sv
// Combinational legality check: every slot select must be a routable code.
module dice_cfg_frame_checker #(
    parameter int NUM_SLOTS = 11,
    parameter int SEL_W     = 4,
    parameter int MAX_SEL   = 8
) (
    input  logic [NUM_SLOTS*SEL_W-1:0] sels,
    output logic                       sel_ok
);

    localparam logic [SEL_W-1:0] MAX_V = SEL_W'(MAX_SEL);

    always_comb begin
        sel_ok = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sels[i*SEL_W +: SEL_W] > MAX_V) begin
                sel_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dice_router_cfg_loader.sv
// Double-buffered configuration loader: stream words build a shadow frame,
// a commit copies it into the active select/regmode registers.
module dice_router_cfg_loader
    import dice_router_cfg_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CFG_W-1:0]           cfg_data,
    input  logic                       cfg_last,
    input  logic                       cfg_commit,
    output logic [NUM_SLOTS*SEL_W-1:0] sel_flat,
    output logic [NUM_SLOTS-1:0]       regmode,
    output logic                       active_valid,
    output logic                       shadow_full,
    output logic                       frame_err,
    output state_t                     state_dbg
);

    // Handshake: a word moves on any rising edge where cfg_valid && cfg_ready;
    // cfg_ready is registered and does not depend on cfg_valid.
    state_t                     state_q;
    logic [BEAT_W-1:0]          beat_q;
    logic [FRAME_W-1:0]         shadow_q;
    logic [FRAME_W-1:0]         frame_next;
    logic [NUM_SLOTS*SEL_W-1:0] next_sels;
    logic [NUM_SLOTS*SEL_W-1:0] shadow_sels;
    logic [NUM_SLOTS-1:0]       shadow_rm;
    logic                       pending_q;
    logic                       sel_ok;
    logic                       xfer;
    logic                       last_beat;
    logic                       done_ok;
    logic                       err_now;

    assign xfer      = cfg_valid && cfg_ready;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign done_ok   = xfer && last_beat && cfg_last && sel_ok;
    assign err_now   = xfer && (last_beat ? !(cfg_last && sel_ok) : cfg_last);
    assign state_dbg = state_q;

    // Overlay the incoming word onto the shadow; bits past FRAME_W drop out.
    always_comb begin
        frame_next = shadow_q;
        for (int b = 0; b < FRAME_W; b++) begin
            if (beat_q == BEAT_W'(b / CFG_W)) begin
                frame_next[b] = cfg_data[b % CFG_W];
            end
        end
    end

    always_comb begin
        next_sels   = '0;
        shadow_sels = '0;
        shadow_rm   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            next_sels[i*SEL_W +: SEL_W]   = frame_next[i*SLOT_W +: SEL_W];
            shadow_sels[i*SEL_W +: SEL_W] = shadow_q[i*SLOT_W +: SEL_W];
            shadow_rm[i]                  = shadow_q[i*SLOT_W + SEL_W];
        end
    end

    dice_cfg_frame_checker #(
        .NUM_SLOTS (NUM_SLOTS),
        .SEL_W     (SEL_W),
        .MAX_SEL   (MAX_SEL)
    ) u_checker (
        .sels   (next_sels),
        .sel_ok (sel_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            cfg_ready    <= 1'b1;
            sel_flat     <= SEL_RESET;
            regmode      <= '0;
            active_valid <= 1'b0;
            shadow_full  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (err_now) begin
                        frame_err <= 1'b1;
                        pending_q <= 1'b0;
                        beat_q    <= '0;
                        shadow_q  <= '0;
                        state_q   <= IDLE;
                    end else begin
                        if (cfg_commit) begin
                            pending_q <= 1'b1;
                        end
                        if (done_ok) begin
                            // A pending commit keeps shadow_full low; FULL then lasts one cycle.
                            shadow_q    <= frame_next;
                            beat_q      <= '0;
                            state_q     <= FULL;
                            cfg_ready   <= 1'b0;
                            shadow_full <= !(pending_q || cfg_commit);
                        end else if (xfer) begin
                            shadow_q <= frame_next;
                            beat_q   <= beat_q + BEAT_W'(1);
                            state_q  <= LOAD;
                        end
                    end
                end
                FULL: begin
                    if (cfg_commit || pending_q) begin
                        sel_flat     <= shadow_sels;
                        regmode      <= shadow_rm;
                        active_valid <= 1'b1;
                        shadow_full  <= 1'b0;
                        pending_q    <= 1'b0;
                        cfg_ready    <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
